// File: rtl/oam_dma_engine_pkg.sv
// Shared types and default bus addresses for the OAM DMA engine.
// State encoding plus the classic trigger/destination register locations.
package dma_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_GET,
        DMA_PUT
    } dma_state_t;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DMA_DST_ADDR  = 16'h2004;

endpackage

// File: rtl/oam_dma_engine_if.sv
// CPU-side and bus-side signal bundle for the OAM DMA engine.
// master = CPU/fabric side, slave = the engine.
interface oam_dma_engine_if
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rw;
    logic              abort;
    logic [DATA_W-1:0] bus_rdata;
    logic              cpu_halt;
    logic              dma_oe;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_rw;
    logic [DATA_W-1:0] dma_wdata;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output cpu_addr, cpu_wdata, cpu_rw, abort, bus_rdata,
        input  cpu_halt, dma_oe, dma_addr, dma_rw, dma_wdata,
        input  busy, done, aborted
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rw, abort, bus_rdata,
        output cpu_halt, dma_oe, dma_addr, dma_rw, dma_wdata,
        output busy, done, aborted
    );

endinterface

// File: rtl/oam_dma_engine.sv
// Page-to-register DMA: halts the CPU, then alternates GET/PUT bus cycles
// copying LEN bytes from {page, idx} to a fixed destination register.
module oam_dma_engine
    import dma_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 8,
    parameter int              LEN       = 256,
    parameter logic [ADDR_W-1:0] TRIG_ADDR = ADDR_W'(DMA_TRIG_ADDR),
    parameter logic [ADDR_W-1:0] DST_ADDR  = ADDR_W'(DMA_DST_ADDR),
    parameter bit              ALIGN_EN  = 1'b1
) (
    input logic               clk,
    input logic               n_reset,
    oam_dma_engine_if.slave   bus
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int PW = ADDR_W - 8;
    localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);

    dma_state_t        state_q;
    dma_state_t        state_d;
    logic              parity_q;
    logic [PW-1:0]     page_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              aborted_q;
    logic              trig;
    logic              last;
    logic              stop;

    assign trig = !bus.cpu_rw && (bus.cpu_addr == TRIG_ADDR);
    assign last = (idx_q == IDX_LAST);
    assign stop = (state_q != DMA_IDLE) && bus.abort;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DMA_IDLE:  if (trig) state_d = DMA_HALT;
            DMA_HALT: begin
                if (bus.cpu_rw)
                    state_d = (ALIGN_EN && parity_q) ? DMA_ALIGN : DMA_GET;
            end
            DMA_ALIGN: state_d = DMA_GET;
            DMA_GET:   state_d = DMA_PUT;
            DMA_PUT:   state_d = last ? DMA_IDLE : DMA_GET;
            default:   state_d = DMA_IDLE;
        endcase
        // abort overrides everything once a transfer owns the bus
        if (stop) state_d = DMA_IDLE;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= DMA_IDLE;
            parity_q  <= 1'b0;
            page_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            parity_q  <= ~parity_q;
            done_q    <= (state_q == DMA_PUT) && last && !bus.abort;
            aborted_q <= stop;
            if (state_q == DMA_IDLE && trig) begin
                page_q <= PW'(bus.cpu_wdata);
                idx_q  <= '0;
            end
            if (state_q == DMA_GET)
                data_q <= bus.bus_rdata;
            if (state_q == DMA_PUT && !last)
                idx_q <= idx_q + 1'b1;
        end
    end

    logic is_get;
    logic is_put;

    assign is_get = (state_q == DMA_GET);
    assign is_put = (state_q == DMA_PUT);

    assign bus.busy      = (state_q != DMA_IDLE);
    assign bus.cpu_halt  = (state_q != DMA_IDLE);
    assign bus.dma_oe    = is_get || is_put;
    assign bus.dma_rw    = !is_put;
    assign bus.dma_wdata = is_put ? data_q : '0;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

    always_comb begin
        bus.dma_addr = '0;
        if (is_get) bus.dma_addr = {page_q, 8'h00} + ADDR_W'(idx_q);
        if (is_put) bus.dma_addr = DST_ADDR;
    end

endmodule
